// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter definitions: FSM states, fixed AR attributes, port indices.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on a tie the port not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant; a lone requester always wins, a tie alternates on 'last'.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between icache (port 0) and dcache (port 1),
// one outstanding burst at a time, round-robin on simultaneous requests.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        r_req_i,
  input  logic [ADDR_W-1:0] r_addr_i [2],
  input  logic [7:0]        r_length_i [2],
  input  logic [1:0]        r_data_ready_i,
  output logic [1:0]        r_rdy_o,
  output logic [1:0]        ret_valid_o,
  output logic [1:0]        ret_last_o,
  output logic [DATA_W-1:0] r_data_o,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);

  state_e     state;
  state_e     state_nxt;
  logic       owner;
  logic       rr_last;
  logic [1:0] grant;

  rr_arb2 u_rr_arb2 (
    .req   (r_req_i),
    .last  (rr_last),
    .grant (grant)
  );

  assign r_data_o = rdata;
  assign arsize   = AXI_SIZE_WORD;
  assign arburst  = AXI_BURST_INCR;
  assign arid     = ID_W'(owner);

  // State register, grant capture and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= PORT_I;
      araddr  <= '0;
      arlen   <= '0;
      rr_last <= PORT_D;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |grant) begin
        owner  <= grant[1];
        araddr <= r_addr_i[grant[1]];
        arlen  <= r_length_i[grant[1]];
      end
      if (state == DATA && rvalid && rready && rlast) begin
        rr_last <= owner;
      end
    end
  end

  // Next state plus the AR/R handshakes and per-port routing of the burst.
  always_comb begin
    state_nxt   = state;
    arvalid     = 1'b0;
    rready      = 1'b0;
    r_rdy_o     = '0;
    ret_valid_o = '0;
    ret_last_o  = '0;
    case (state)
      IDLE: begin
        if (|r_req_i) state_nxt = ADDR;
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          r_rdy_o[owner] = 1'b1;
          state_nxt      = DATA;
        end
      end
      DATA: begin
        rready             = r_data_ready_i[owner];
        ret_valid_o[owner] = rvalid;
        ret_last_o[owner]  = rvalid & rlast;
        if (rvalid && rready && rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requesters must hold their request until accepted.
  a_req0_held: assert property (@(posedge clk) disable iff (rst)
    (r_req_i[0] && !r_rdy_o[0]) |=> r_req_i[0]);
  a_req1_held: assert property (@(posedge clk) disable iff (rst)
    (r_req_i[1] && !r_rdy_o[1]) |=> r_req_i[1]);

  // Returned beats must carry the owner's ID.
  a_rid_match: assert property (@(posedge clk) disable iff (rst)
    (state == DATA && rvalid) |-> (rid == ID_W'(owner)));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized
// bursts checked against a transaction-level round-robin model.
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        r_req_i;
  logic [ADDR_W-1:0] r_addr_i [2];
  logic [7:0]        r_length_i [2];
  logic [1:0]        r_data_ready_i;
  logic [1:0]        r_rdy_o;
  logic [1:0]        ret_valid_o;
  logic [1:0]        ret_last_o;
  logic [DATA_W-1:0] r_data_o;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  int checks   = 0;
  int failures = 0;
  int mdl_last = 1;  // model: port that completed the most recent burst

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .r_req_i        (r_req_i),
    .r_addr_i       (r_addr_i),
    .r_length_i     (r_length_i),
    .r_data_ready_i (r_data_ready_i),
    .r_rdy_o        (r_rdy_o),
    .ret_valid_o    (ret_valid_o),
    .ret_last_o     (ret_last_o),
    .r_data_o       (r_data_o),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .arlen          (arlen),
    .arsize         (arsize),
    .arburst        (arburst),
    .arid           (arid),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .rlast          (rlast),
    .rid            (rid)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Reference rule: lone requester wins; a tie goes to the port not served last.
  function automatic int model_winner(input logic [1:0] mask);
    if (mask == 2'b11) return (mdl_last == 0) ? 1 : 0;
    return mask[1] ? 1 : 0;
  endfunction

  task automatic request(input int p, input logic [31:0] addr, input logic [7:0] len);
    r_addr_i[p]   = addr;
    r_length_i[p] = len;
    r_req_i[p]    = 1'b1;
  endtask

  // Acts as the AXI slave for one burst owned by port p; called at posedge+1.
  task automatic serve_burst(input int p, input logic [31:0] addr, input logic [7:0] len,
                             input int ar_delay, input int bp_mask, input int gap_mask,
                             output int wait_cyc);
    logic [1:0]      oh;
    logic [ID_W-1:0] exp_id;
    logic            rdy, bp_done, gap_done;
    int              b, guard, delivered;
    oh       = (p == 0) ? 2'b01 : 2'b10;
    exp_id   = p[ID_W-1:0];
    arready  = (ar_delay == 0);
    wait_cyc = 0;
    @(negedge clk);
    while (arvalid !== 1'b1 && wait_cyc < 50) begin
      wait_cyc++;
      @(negedge clk);
    end
    checks++;
    if (arvalid !== 1'b1) begin
      failures++;
      $display("FAIL ar_timeout port=%0d arvalid=%b required=1", p, arvalid);
      arready = 1'b0;
      return;
    end
    checks++;
    if (araddr !== addr) begin failures++; $display("FAIL araddr port=%0d got=%h exp=%h", p, araddr, addr); end
    checks++;
    if (arlen !== len) begin failures++; $display("FAIL arlen port=%0d got=%0d exp=%0d", p, arlen, len); end
    checks++;
    if (arid !== exp_id) begin failures++; $display("FAIL arid port=%0d got=%0d exp=%0d", p, arid, exp_id); end
    checks++;
    if (arsize !== 3'b010 || arburst !== 2'b01) begin
      failures++; $display("FAIL ar_attr got size=%b burst=%b exp size=010 burst=01", arsize, arburst);
    end
    for (int d = 0; d < ar_delay; d++) begin
      checks++;
      if (r_rdy_o !== 2'b00) begin failures++; $display("FAIL rdy_early cycle=%0d got=%b exp=00", d, r_rdy_o); end
      @(posedge clk); #1;
      if (d == ar_delay - 1) arready = 1'b1;
      @(negedge clk);
      checks++;
      if (arvalid !== 1'b1 || araddr !== addr) begin
        failures++; $display("FAIL ar_hold cycle=%0d got arvalid=%b araddr=%h exp 1 %h", d, arvalid, araddr, addr);
      end
    end
    checks++;
    if (r_rdy_o !== oh) begin failures++; $display("FAIL rdy_pulse port=%0d got=%b exp=%b", p, r_rdy_o, oh); end
    @(posedge clk); #1;
    arready    = 1'b0;
    r_req_i[p] = 1'b0;

    b = 0; guard = 0; delivered = 0; bp_done = 1'b0; gap_done = 1'b0;
    while (b <= int'(len) && guard < 300) begin
      guard++;
      if (((gap_mask >> b) & 1) != 0 && !gap_done) begin
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rdy      = 1'b1;
        gap_done = 1'b1;
      end else begin
        rvalid = 1'b1;
        rdata  = $urandom;
        rlast  = (b == int'(len));
        rid    = exp_id;
        rdy    = !(((bp_mask >> b) & 1) != 0 && !bp_done);
        if (!rdy) bp_done = 1'b1;
      end
      r_data_ready_i[p]     = rdy;
      r_data_ready_i[1 - p] = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (rready !== rdy) begin failures++; $display("FAIL rready beat=%0d got=%b exp=%b", b, rready, rdy); end
      checks++;
      if (ret_valid_o !== (rvalid ? oh : 2'b00)) begin
        failures++; $display("FAIL ret_valid beat=%0d got=%b exp=%b", b, ret_valid_o, rvalid ? oh : 2'b00);
      end
      checks++;
      if (ret_last_o !== ((rvalid && rlast) ? oh : 2'b00)) begin
        failures++; $display("FAIL ret_last beat=%0d got=%b exp=%b", b, ret_last_o, (rvalid && rlast) ? oh : 2'b00);
      end
      checks++;
      if (r_data_o !== rdata) begin failures++; $display("FAIL r_data beat=%0d got=%h exp=%h", b, r_data_o, rdata); end
      checks++;
      if (r_rdy_o !== 2'b00 || arvalid !== 1'b0) begin
        failures++; $display("FAIL data_phase_ar beat=%0d got rdy=%b arvalid=%b exp 00 0", b, r_rdy_o, arvalid);
      end
      if (ret_valid_o[p] === 1'b1 && rready === 1'b1) delivered++;
      if (rvalid && rdy) begin
        b++;
        bp_done  = 1'b0;
        gap_done = 1'b0;
      end
      @(posedge clk); #1;
    end
    rvalid         = 1'b0;
    rlast          = 1'b0;
    r_data_ready_i = 2'b00;
    checks++;
    if (delivered != int'(len) + 1) begin
      failures++; $display("FAIL beat_count port=%0d got=%0d exp=%0d", p, delivered, int'(len) + 1);
    end
    mdl_last = p;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (arvalid !== 1'b0 || araddr !== '0 || arlen !== '0 || arid !== '0) begin
      failures++; $display("FAIL %s_ar got arvalid=%b araddr=%h arlen=%0d arid=%0d exp all 0", tag, arvalid, araddr, arlen, arid);
    end
    checks++;
    if (rready !== 1'b0 || r_rdy_o !== 2'b00 || ret_valid_o !== 2'b00 || ret_last_o !== 2'b00) begin
      failures++; $display("FAIL %s_r got rready=%b rdy=%b rv=%b rl=%b exp all 0", tag, rready, r_rdy_o, ret_valid_o, ret_last_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; r_req_i = 2'b00; r_data_ready_i = 2'b11; arready = 1'b1;
    r_addr_i[0] = '0; r_addr_i[1] = '0; r_length_i[0] = '0; r_length_i[1] = '0;
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rlast = 1'b1; rid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    checks++;
    if (arsize !== 3'b010 || arburst !== 2'b01) begin
      failures++; $display("FAIL reset_attr got size=%b burst=%b exp 010 01", arsize, arburst);
    end
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0; r_data_ready_i = 2'b00;
    mdl_last = 1;
  endtask

  task automatic test_single_icache();
    int w;
    request(0, 32'h1C000040, 8'd15);
    serve_burst(0, 32'h1C000040, 8'd15, 0, 0, 0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", w); end
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin
      failures++; $display("FAIL single_idle got arvalid=%b rready=%b exp 0 0", arvalid, rready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    int w, p;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mdl_last = 1;
    for (int round = 0; round < 2; round++) begin
      request(0, 32'h00001000 + 32'(round * 64), 8'd15);
      request(1, 32'h80002000 + 32'(round * 64), 8'd0);
      p = model_winner(2'b11);
      serve_burst(p, r_addr_i[p], r_length_i[p], 0, 0, 0, w);
      checks++;
      if (w != 1) begin failures++; $display("FAIL tie_first_latency round=%0d got=%0d exp=1", round, w); end
      serve_burst(1 - p, r_addr_i[1 - p], r_length_i[1 - p], 0, 0, 0, w);
      checks++;
      if (w != 1) begin failures++; $display("FAIL tie_bubble round=%0d got=%0d exp=1", round, w); end
    end
  endtask

  task automatic test_ar_delay();
    int w;
    request(1, 32'h40000100, 8'd3);
    serve_burst(1, 32'h40000100, 8'd3, 5, 0, 0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL ardelay_latency got=%0d exp=1", w); end
  endtask

  task automatic test_backpressure();
    int w;
    request(1, 32'h20000200, 8'd7);
    serve_burst(1, 32'h20000200, 8'd7, 0, 32'b110, 0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL bp_latency got=%0d exp=1", w); end
  endtask

  task automatic test_spurious_rvalid();
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rlast = 1'(i & 1); rdata = $urandom; r_data_ready_i = 2'b11;
      @(negedge clk);
      checks++;
      if (rready !== 1'b0 || ret_valid_o !== 2'b00 || ret_last_o !== 2'b00) begin
        failures++; $display("FAIL spurious got rready=%b rv=%b rl=%b exp 0 00 00", rready, ret_valid_o, ret_last_o);
      end
      checks++;
      if (r_data_o !== rdata) begin failures++; $display("FAIL spurious_data got=%h exp=%h", r_data_o, rdata); end
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0; r_data_ready_i = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    int cnt, w, p;
    request(0, 32'h1C000080, 8'd15);
    arready = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (arvalid !== 1'b1 && cnt < 50) begin cnt++; @(negedge clk); end
    checks++;
    if (r_rdy_o !== 2'b01) begin failures++; $display("FAIL midrst_grant got=%b exp=01", r_rdy_o); end
    @(posedge clk); #1;
    r_req_i[0] = 1'b0; arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1; rdata = $urandom; rlast = 1'b0; rid = '0; r_data_ready_i = 2'b11;
      @(negedge clk);
      checks++;
      if (ret_valid_o !== 2'b01) begin failures++; $display("FAIL midrst_beat%0d got=%b exp=01", b, ret_valid_o); end
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rdata = $urandom; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk); #1;
    rvalid = 1'b0; r_data_ready_i = 2'b00;
    mdl_last = 1;
    request(0, 32'h00400000, 8'd2);
    request(1, 32'h00500000, 8'd1);
    p = model_winner(2'b11);
    serve_burst(p, r_addr_i[p], r_length_i[p], 1, 0, 0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL midrst_regrant got=%0d exp=1", w); end
    serve_burst(1 - p, r_addr_i[1 - p], r_length_i[1 - p], 0, 0, 0, w);
  endtask

  task automatic test_random();
    int pend = -1;
    int w, p;
    logic [1:0] mask;
    for (int it = 0; it < 14; it++) begin
      if (pend >= 0) begin
        p = pend; pend = -1;
      end else begin
        mask = 2'($urandom_range(1, 3));
        for (int k = 0; k < 2; k++)
          if (mask[k]) request(k, $urandom & 32'hFFFFFFFC, 8'($urandom_range(0, 7)));
        p = model_winner(mask);
        if (mask == 2'b11) pend = 1 - p;
      end
      serve_burst(p, r_addr_i[p], r_length_i[p], $urandom_range(0, 3), int'($urandom & 32'hFF), int'($urandom & 32'hFF), w);
      checks++;
      if (w != 1) begin failures++; $display("FAIL random_latency iter=%0d got=%0d exp=1", it, w); end
    end
    if (pend >= 0) serve_burst(pend, r_addr_i[pend], r_length_i[pend], 0, 0, 0, w);
  endtask

  initial begin
    test_reset();
    test_single_icache();
    test_tie();
    test_ar_delay();
    test_backpressure();
    test_spurious_rvalid();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
